// File: rtl/spi_slave_pkg.sv
// Shared state encoding, default opcodes and width helpers for the SPI slave command engine.
package spi_slave_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CMD     = 3'd1;
  localparam state_t ST_ADDR    = 3'd2;
  localparam state_t ST_RD_WAIT = 3'd3;
  localparam state_t ST_RD_DATA = 3'd4;
  localparam state_t ST_WR_DATA = 3'd5;
  localparam state_t ST_IGNORE  = 3'd6;

  localparam logic [7:0] CMD_READ_DEF  = 8'h03;
  localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_slave_cmd_engine_shift.sv
// Datapath for the SPI slave: rx shift register, tx load/shift register and field bit counter.
// clr (cs_n high) wipes all state on the next edge; rst clears it asynchronously.
module spi_shift_unit #(
  parameter int RX_W   = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              data_in,
  input  logic              cnt_en,
  input  logic              cnt_last,
  input  logic              tx_load,
  input  logic [DATA_W-1:0] tx_word,
  input  logic              tx_shift,
  output logic [RX_W-1:0]   rx_next,
  output logic [CNT_W-1:0]  cnt,
  output logic              tx_msb
);

  logic [RX_W-2:0]   rx_reg;
  logic [DATA_W-1:0] tx_reg;

  // The field decode happens on the edge that samples the last bit, so the FSM sees the word including data_in.
  assign rx_next = {rx_reg, data_in};
  assign tx_msb  = tx_reg[DATA_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_reg <= '0;
      tx_reg <= '0;
      cnt    <= '0;
    end else if (clr) begin
      rx_reg <= '0;
      tx_reg <= '0;
      cnt    <= '0;
    end else begin
      rx_reg <= rx_next[RX_W-2:0];
      if (cnt_en) cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
      if (tx_load) tx_reg <= tx_word;
      else if (tx_shift) tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_slave_cmd_engine.sv
// SPI slave transaction engine: opcode, ADDR_W-bit address, DATA_W-bit data; strobes a single-port register file.
// SPI_SLAVE_CMD_AUTOINC_EN enables write/read bursts with address auto-increment.
module spi_slave_cmd_engine
  import spi_slave_pkg::*;
#(
  parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
  parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF,
  parameter int         ADDR_W    = 16,
  parameter int         DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              data_in,
  output logic              data_out,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              cmd_err,
  output logic              busy
);

  localparam int RX_W  = max3(8, ADDR_W, DATA_W);
  localparam int CNT_W = clog2w(RX_W);

  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
`ifdef SPI_SLAVE_CMD_AUTOINC_EN
  localparam logic [CNT_W-1:0] PRE_DATA  = CNT_W'(DATA_W - 2);
`endif

  state_t           state;
  logic             is_read;
  logic [RX_W-1:0]  rx_next;
  logic [CNT_W-1:0] cnt;
  logic             tx_msb;
  logic             cnt_en;
  logic             cnt_last;
  logic             tx_load;
  logic             tx_shift;

  spi_shift_unit #(
    .RX_W   (RX_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (cs_n),
    .data_in  (data_in),
    .cnt_en   (cnt_en),
    .cnt_last (cnt_last),
    .tx_load  (tx_load),
    .tx_word  (rd_data),
    .tx_shift (tx_shift),
    .rx_next  (rx_next),
    .cnt      (cnt),
    .tx_msb   (tx_msb)
  );

  assign busy     = (state != ST_IDLE);
  assign data_out = (state == ST_RD_DATA) && tx_msb;

  always_comb begin
    cnt_en   = 1'b0;
    cnt_last = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    case (state)
      ST_IDLE:    cnt_en = 1'b1;
      ST_CMD: begin
        cnt_en   = 1'b1;
        cnt_last = (cnt == LAST_CMD);
      end
      ST_ADDR: begin
        cnt_en   = 1'b1;
        cnt_last = (cnt == LAST_ADDR);
      end
      ST_RD_WAIT: tx_load = 1'b1;
      ST_RD_DATA: begin
        cnt_en   = 1'b1;
        cnt_last = (cnt == LAST_DATA);
        tx_shift = 1'b1;
`ifdef SPI_SLAVE_CMD_AUTOINC_EN
        tx_load  = cnt_last;
`endif
      end
      ST_WR_DATA: begin
        cnt_en   = 1'b1;
        cnt_last = (cnt == LAST_DATA);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      is_read <= 1'b0;
      addr    <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      cmd_err <= 1'b0;
      if (cs_n) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_CMD;
          ST_CMD: if (cnt_last) begin
            if (rx_next[7:0] == CMD_READ) begin
              is_read <= 1'b1;
              state   <= ST_ADDR;
            end else if (rx_next[7:0] == CMD_WRITE) begin
              is_read <= 1'b0;
              state   <= ST_ADDR;
            end else begin
              cmd_err <= 1'b1;
              state   <= ST_IGNORE;
            end
          end
          ST_ADDR: if (cnt_last) begin
            addr <= rx_next[ADDR_W-1:0];
            if (is_read) begin
              rd_en <= 1'b1;
              state <= ST_RD_WAIT;
            end else begin
              state <= ST_WR_DATA;
            end
          end
          ST_RD_WAIT: state <= ST_RD_DATA;
          ST_RD_DATA: begin
`ifdef SPI_SLAVE_CMD_AUTOINC_EN
            // Prefetch the next word while the current LSB is on the wire so words stream back to back.
            if (cnt == PRE_DATA) begin
              rd_en <= 1'b1;
              addr  <= addr + ADDR_W'(1);
            end
`else
            if (cnt_last) state <= ST_IGNORE;
`endif
          end
          ST_WR_DATA: if (cnt_last) begin
            wr_data <= rx_next[DATA_W-1:0];
            wr_en   <= 1'b1;
`ifndef SPI_SLAVE_CMD_AUTOINC_EN
            state   <= ST_IGNORE;
`endif
          end
          default: ;
        endcase
      end
`ifdef SPI_SLAVE_CMD_AUTOINC_EN
      if (wr_en) addr <= addr + ADDR_W'(1);
`endif
    end
  end

endmodule

// File: doc/spi_slave_cmd_engine.md
Name: spi_slave_cmd_engine

Overview:
- Parametrised SPI slave transaction engine; successor to the fixed 8-bit command shifter.
- Frames transactions with cs_n, captures the command, then an ADDR_W-bit address, then DATA_W-bit data.
- Drives a single-port register/memory interface: write strobe, or read strobe with serial return on data_out.
- Sits between the SPI pins (clk = SCLK) and the register file.

Parameters:
- CMD_READ, 8'h03, opcode for read transaction
- CMD_WRITE, 8'h02, opcode for write transaction
- ADDR_W, 16, address field width in bits (8..32)
- DATA_W, 8, data word width in bits (2..32)

Ports:
- clk  in  1  SPI bit clock; all sampling on rising edge
- rst  in  1  asynchronous, active-high reset
- cs_n  in  1  chip select, active low, sampled on clk
- data_in  in  1  MOSI, MSB first
- data_out  out  1  MISO, MSB first
- addr  out  ADDR_W  transaction address
- wr_en  out  1  one-cycle write strobe
- wr_data  out  DATA_W  write word, valid with wr_en
- rd_en  out  1  one-cycle read strobe
- rd_data  in  DATA_W  read word, valid one clk after rd_en
- cmd_err  out  1  one-cycle pulse on an unknown opcode
- busy  out  1  high while state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- cs_n high at any edge forces IDLE and clears the counters and shift registers. A partial word is discarded: no wr_en is issued.
- States: IDLE, CMD, ADDR, RD_WAIT, RD_DATA, WR_DATA, IGNORE.
- IDLE -> CMD: on the first edge with cs_n low; that edge samples bit 7 of the opcode.
- CMD: 8 bits shifted in.
  - At the 8th edge, compare against CMD_READ / CMD_WRITE.
  - Match -> ADDR.
  - No match -> IGNORE, and cmd_err is registered high for the following cycle.
- ADDR: ADDR_W bits shifted in. addr is loaded at the last-bit edge.
  - Read -> RD_WAIT, with rd_en registered high for the next cycle.
  - Write -> WR_DATA.
- RD_WAIT: exactly one dummy clk. At its edge, tx_reg <= rd_data and state -> RD_DATA. data_out = tx_reg MSB from then on.
- RD_DATA: tx_reg shifts left each edge for DATA_W bits. After the last bit -> IGNORE (base build).
- WR_DATA: DATA_W bits shifted in. At the last-bit edge, wr_data is loaded and wr_en is registered high for one cycle. Then -> IGNORE (base build).
- IGNORE: data_in is discarded, data_out = 0, held until cs_n rises.
- data_out is 0 in every state except RD_DATA.
- Bit counter width: clog2 of max(8, ADDR_W, DATA_W); it reloads at each field boundary.
- wr_en and rd_en are never high in the same cycle. Each is high for at most one cycle per word.

Optional Feature:
- Macro: SPI_SLAVE_CMD_AUTOINC_EN. When defined, bursts are enabled.
- Write burst: after each wr_en, addr increments by 1, wrapping modulo 2^ADDR_W, and the engine stays in WR_DATA for the next word.
- Read burst:
  - rd_en is asserted for addr+1 during the cycle in which the current word's LSB is on data_out.
  - addr updates at that same edge.
  - tx_reg reloads at the following edge, so words stream with no dummy clk between them.
- Without the macro: one word per transaction, then IGNORE; addr never increments.

Decomposition:
- Package spi_slave_pkg:
  - state enum;
  - default opcode constants CMD_READ_DEF = 8'h03, CMD_WRITE_DEF = 8'h02;
  - clog2 width helper function.
- One natural sub-module: spi_shift_unit, holding the rx shift register, tx load/shift register and bit counter. The FSM stays in the top.

Test Plan:
- Write: cs_n low; 0x02, addr 0x1234, data 0xA5 (ADDR_W=16, DATA_W=8) -> one wr_en pulse with addr=0x1234, wr_data=0xA5, exactly one cycle after the 32nd edge.
- Read: 0x03, addr 0x00FF, rd_data model returns 0x3C one clk after rd_en -> rd_en one cycle after the 24th edge; after one dummy clk, data_out carries 0,0,1,1,1,1,0,0.
- Bad opcode 0x9F -> cmd_err pulses once; no rd_en/wr_en; data_out stays 0 until cs_n high.
- cs_n raised after 4 data bits of a write -> no wr_en, busy falls; the next transaction decodes correctly.
- rst asserted mid-address -> all outputs 0 immediately (asynchronous); a fresh 0x02 transaction after release works.
- AUTOINC_EN: write burst to 0xFFFF with 2 words -> wr_en at 0xFFFF then at 0x0000. Read burst of 3 words -> contiguous 24 bits on data_out with no gap.
